// File: rtl/display_timing_480p.sv
// Raster timing generator for 640x480p60: sync, data-enable, coordinates and
// frame/line strobes, all registered and aligned to the presented (sx, sy).
module display_timing_480p #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0,
  parameter int FCW    = 16
) (
  input  logic             clk_pix,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic [FCW-1:0]   frame_count
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACTIVE = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACTIVE = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG   = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_BEG   = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_RES + V_FP + V_SYNC - 1);
  localparam logic             H_ON     = 1'(H_POL);
  localparam logic             V_ON     = 1'(V_POL);

  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic [FCW-1:0]   fc_q, fc_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             frame_q, frame_d;
  logic             line_q, line_d;

  // Strobes and syncs are decoded from the next-state position so they
  // land in the same cycle as the coordinates they describe.
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      if (sy_q == V_LAST) begin
        sy_d = '0;
      end else begin
        sy_d = sy_q + 1'b1;
      end
    end else begin
      sx_d = sx_q + 1'b1;
    end

    de_d    = (sx_d < H_ACTIVE) && (sy_d < V_ACTIVE);
    hsync_d = ((sx_d >= HS_BEG) && (sx_d <= HS_END)) ? H_ON : ~H_ON;
    vsync_d = ((sy_d >= VS_BEG) && (sy_d <= VS_END)) ? V_ON : ~V_ON;
    line_d  = (sx_d == '0);
    frame_d = line_d && (sy_d == '0);
    fc_d    = frame_d ? fc_q + 1'b1 : fc_q;
  end

  // Reset parks the raster on the last position so the first edge opens a frame.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      fc_q    <= '0;
      hsync_q <= ~H_ON;
      vsync_q <= ~V_ON;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      fc_q    <= fc_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      frame_q <= frame_d;
      line_q  <= line_d;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign frame_count = fc_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame       = frame_q;
  assign line        = line_q;

endmodule

// File: tb/tb_display_timing_480p.sv
// Self-checking bench: three timing configurations compared every cycle
// against an arithmetic raster model, with randomized mid-frame resets.
module tb_display_timing_480p;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fr;
    logic        ln;
    logic [31:0] sx;
    logic [31:0] sy;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst = 1'b1;
  int   k = 0;
  int   checks = 0;
  int   errors = 0;

  logic a_hs, a_vs, a_de, a_fr, a_ln;
  logic [9:0] a_sx, a_sy;
  logic [15:0] a_fc;
  logic b_hs, b_vs, b_de, b_fr, b_ln;
  logic [9:0] b_sx, b_sy;
  logic [2:0] b_fc;
  logic c_hs, c_vs, c_de, c_fr, c_ln;
  logic [9:0] c_sx, c_sy;
  logic [15:0] c_fc;

  display_timing_480p dut_a (
    .clk_pix(clk), .rst(rst), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .frame(a_fr), .line(a_ln), .sx(a_sx), .sy(a_sy), .frame_count(a_fc)
  );

  display_timing_480p #(
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_RES(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1), .FCW(3)
  ) dut_b (
    .clk_pix(clk), .rst(rst), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .frame(b_fr), .line(b_ln), .sx(b_sx), .sy(b_sy), .frame_count(b_fc)
  );

  display_timing_480p #(
    .V_RES(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_c (
    .clk_pix(clk), .rst(rst), .hsync(c_hs), .vsync(c_vs), .de(c_de),
    .frame(c_fr), .line(c_ln), .sx(c_sx), .sy(c_sy), .frame_count(c_fc)
  );

  always begin
    #5;
    if (clk_en || clk) clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t k=%0d)", tag, obs, exp, $time, k);
    end
  endtask

  // Raster position after n edges since reset release, from plain arithmetic.
  function automatic exp_t model(input int n, input int hres, input int hfp, input int hsw,
                                 input int hbp, input int vres, input int vfp, input int vsw,
                                 input int vbp, input int hpol, input int vpol, input int fcw);
    exp_t e;
    int ht, vt, p, x, y;
    ht = hres + hfp + hsw + hbp;
    vt = vres + vfp + vsw + vbp;
    if (n == 0) begin
      e.sx = ht - 1; e.sy = vt - 1;
      e.hs = (hpol == 0); e.vs = (vpol == 0);
      e.de = 1'b0; e.fr = 1'b0; e.ln = 1'b0; e.fc = 32'd0;
    end else begin
      p = (n - 1) % (ht * vt);
      x = p % ht;
      y = p / ht;
      e.sx = x; e.sy = y;
      e.de = (x < hres) && (y < vres);
      e.hs = (x >= hres + hfp && x < hres + hfp + hsw) ? (hpol != 0) : (hpol == 0);
      e.vs = (y >= vres + vfp && y < vres + vfp + vsw) ? (vpol != 0) : (vpol == 0);
      e.ln = (x == 0);
      e.fr = (p == 0);
      e.fc = (((n - 1) / (ht * vt)) + 1) % (1 << fcw);
    end
    return e;
  endfunction

  task automatic check_dut(input string nm, input exp_t e, input logic hs, input logic vs,
                           input logic de, input logic fr, input logic ln,
                           input logic [31:0] sx, input logic [31:0] sy, input logic [31:0] fc);
    check_eq({nm, ".sx"}, sx, e.sx);
    check_eq({nm, ".sy"}, sy, e.sy);
    check_eq({nm, ".hsync"}, {31'd0, hs}, {31'd0, e.hs});
    check_eq({nm, ".vsync"}, {31'd0, vs}, {31'd0, e.vs});
    check_eq({nm, ".de"}, {31'd0, de}, {31'd0, e.de});
    check_eq({nm, ".frame"}, {31'd0, fr}, {31'd0, e.fr});
    check_eq({nm, ".line"}, {31'd0, ln}, {31'd0, e.ln});
    check_eq({nm, ".fcount"}, fc, e.fc);
  endtask

  task automatic check_all();
    check_dut("a", model(k, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 16),
              a_hs, a_vs, a_de, a_fr, a_ln, 32'(a_sx), 32'(a_sy), 32'(a_fc));
    check_dut("b", model(k, 8, 2, 3, 1, 4, 1, 1, 1, 1, 1, 3),
              b_hs, b_vs, b_de, b_fr, b_ln, 32'(b_sx), 32'(b_sy), 32'(b_fc));
    check_dut("c", model(k, 640, 16, 96, 48, 6, 2, 2, 2, 0, 0, 16),
              c_hs, c_vs, c_de, c_fr, c_ln, 32'(c_sx), 32'(c_sy), 32'(c_fc));
  endtask

  // Aggregate counters over the first window after the initial release.
  int a_de_cnt = 0, a_hs_cnt = 0, a_ln_cnt = 0;
  int c_de_cnt = 0, c_vs_cnt = 0, c_fr_cnt = 0;
  int last_a_ln = 0, last_b_fr = 0, last_c_fr = 0;
  logic c_vs_prev = 1'b1;

  task automatic step();
    @(posedge clk);
    if (!rst) k++;
    @(negedge clk);
    check_all();
    if (k >= 1 && k <= 1600) begin
      a_de_cnt += int'(a_de);
      a_hs_cnt += int'(!a_hs);
      a_ln_cnt += int'(a_ln);
    end
    if (k >= 1 && k <= 19200) begin
      c_de_cnt += int'(c_de);
      c_vs_cnt += int'(!c_vs);
      c_fr_cnt += int'(c_fr);
    end
    if (a_ln) begin
      if (last_a_ln > 0) check_eq("a.line_period", 32'(k - last_a_ln), 32'd800);
      last_a_ln = k;
    end
    if (b_fr) begin
      if (last_b_fr > 0) check_eq("b.frame_period", 32'(k - last_b_fr), 32'd98);
      last_b_fr = k;
    end
    if (c_fr) begin
      if (last_c_fr > 0) check_eq("c.frame_period", 32'(k - last_c_fr), 32'd9600);
      last_c_fr = k;
    end
    if (k >= 2 && c_vs !== c_vs_prev) check_eq("c.vsync_edge_sx", 32'(c_sx), 32'd0);
    c_vs_prev = c_vs;
  endtask

  // Asserts reset between edges and checks the asynchronous return to reset values.
  task automatic apply_reset(input int hold);
    #2;
    rst = 1'b1;
    k = 0;
    last_a_ln = 0; last_b_fr = 0; last_c_fr = 0;
    #1;
    check_all();
    for (int i = 0; i < hold; i++) step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) step();

    // Release with the clock stopped: outputs must hold reset values.
    clk_en = 1'b0;
    rst = 1'b0;
    #40;
    check_all();
    clk_en = 1'b1;

    for (int i = 0; i < 20000; i++) step();
    check_eq("a.de_cycles_2lines", 32'(a_de_cnt), 32'd1280);
    check_eq("a.hsync_cycles_2lines", 32'(a_hs_cnt), 32'd192);
    check_eq("a.line_pulses_2lines", 32'(a_ln_cnt), 32'd2);
    check_eq("c.de_cycles_2frames", 32'(c_de_cnt), 32'd7680);
    check_eq("c.vsync_cycles_2frames", 32'(c_vs_cnt), 32'd3200);
    check_eq("c.frame_pulses_2frames", 32'(c_fr_cnt), 32'd2);

    for (int r = 0; r < 4; r++) begin
      apply_reset(int'($urandom_range(1, 4)));
      for (int i = 0; i < int'($urandom_range(50, 3000)); i++) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_timing_480p.md
Name: display_timing_480p

Overview:
Raster timing generator for 640x480p60 video, driven by the buffered pixel clock and lock output of the 480p clock generator. Produces the horizontal and vertical sync pulses, data-enable, screen coordinates and frame/line strobes. Graphics drawing logic and the VGA/DVI output stages consume these signals. Reset is driven from the inverted clock-locked signal, so timing starts only once the pixel clock is stable.

Parameters:
CORDW, 10, width of the sx/sy coordinate outputs (must hold H_TOTAL-1 and V_TOTAL-1)
H_RES, 640, active pixels per line
H_FP, 16, horizontal front porch, in pixels
H_SYNC, 96, horizontal sync width, in pixels
H_BP, 48, horizontal back porch, in pixels
V_RES, 480, active lines per frame
V_FP, 10, vertical front porch, in lines
V_SYNC, 2, vertical sync width, in lines
V_BP, 33, vertical back porch, in lines
H_POL, 0, hsync level while the pulse is active (0 = negative polarity)
V_POL, 0, vsync level while the pulse is active
FCW, 16, width of the frame counter

Ports:
clk_pix  in  1  pixel clock; all logic on its rising edge
rst  in  1  reset, asynchronous, active-high (driven by !clk_locked)
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable; high in the active area
frame  out  1  one-cycle strobe at the first pixel of a frame
line  out  1  one-cycle strobe at the first pixel of each line
sx  out  CORDW  horizontal position, 0..H_TOTAL-1
sy  out  CORDW  vertical position, 0..V_TOTAL-1
frame_count  out  FCW  count of frames started since reset, wraps

Behaviour:
- H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800 at defaults). V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (525 at defaults).
- Every output is a register clocked by clk_pix and cleared asynchronously by rst. There are no combinational paths from input to output.
- Reset values:
  - sx = H_TOTAL-1, sy = V_TOTAL-1 (the last position of a frame).
  - hsync = !H_POL, vsync = !V_POL.
  - de = 0, frame = 0, line = 0, frame_count = 0.
- Counter update on each clk_pix edge when not in reset:
  - If sx == H_TOTAL-1: sx <= 0. Then if sy == V_TOTAL-1, sy <= 0; otherwise sy <= sy+1.
  - Otherwise: sx <= sx+1, and sy holds.
- Alignment rule: hsync, vsync, de, frame and line always describe the (sx, sy) presented in the same cycle. They are decoded from the next-state counter values, so there is no one-cycle skew.
- de = 1 iff sx < H_RES and sy < V_RES.
- hsync = H_POL iff H_RES+H_FP <= sx <= H_RES+H_FP+H_SYNC-1 (656..751 at defaults); otherwise !H_POL.
- vsync = V_POL iff V_RES+V_FP <= sy <= V_RES+V_FP+V_SYNC-1 (490..491 at defaults); otherwise !V_POL. vsync changes level only on a cycle where sx == 0.
- line = 1 iff sx == 0. frame = 1 iff sx == 0 and sy == 0. When frame is high, line is also high.
- frame_count increments by 1 in the same cycle frame asserts. The first frame after reset therefore shows frame_count = 1. It wraps from 2^FCW-1 to 0 with no flag.
- First edge after reset release: sx=0, sy=0, de=1, frame=1, line=1, frame_count=1.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). There is no partial-frame recovery; timing restarts as described above.
- rst released while clk_pix is not toggling: outputs hold their reset values until the first edge.
- Per line: exactly H_RES de-high cycles and H_SYNC hsync-active cycles.
- Per frame: exactly V_RES de-high lines and V_SYNC vsync-active lines. The frame period is H_TOTAL*V_TOTAL = 420000 cycles.

Test Plan:
- Reset hold: assert rst for 5 cycles, release -> during reset sx=799, sy=524, de=0, hsync=vsync=1. First edge after release: sx=0, sy=0, frame=1, line=1, de=1, frame_count=1.
- Line timing: run 2 lines -> de high for sx 0..639 only; hsync low for exactly 96 cycles, at sx 656..751; line pulses 800 cycles apart; sy increments as sx wraps 799->0.
- Frame timing: run 2 full frames -> frame pulses 420000 cycles apart; vsync low for lines 490..491 only (1600 cycles), edges at sx=0; 480 de-high lines per frame; frame_count 1 then 2.
- Async reset mid-frame: assert rst between edges at sx=300, sy=200 -> outputs reach reset values before the next edge. After release, the next frame pulse occurs on the first edge.
- Polarity and small timing: H_POL=1, V_POL=1, H_RES=8, H_FP=2, H_SYNC=3, H_BP=1, V_RES=4, V_FP=1, V_SYNC=1, V_BP=1, FCW=3 -> hsync high at sx 10..12, vsync high at sy 5, frame period 14*7=98 cycles, frame_count wraps 7->0 on the 8th frame after reset.
